// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: mult/div sequencer
// state encoding, the hard-wired zero register number and a hazard helper.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when a producer writes a real register that one of the Decode sources reads.
    function automatic logic reg_match(input logic [4:0] dst,
                                       input logic [4:0] src_a,
                                       input logic [4:0] src_b);
        return (dst != REG_ZERO) && ((dst == src_a) || (dst == src_b));
    endfunction

endpackage

// File: rtl/stall_ctrl_md_seq.sv
// Multi-cycle mult/div sequencer: IDLE -> BUSY (MD_LAT cycles) -> DONE -> IDLE.
// A start request is only honoured in IDLE; Decode stalls keep a second
// mult/div from reaching Execute while the unit is occupied.
module md_seq
    import mips_pkg::*;
#(
    parameter int MD_LAT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic md_start_i,
    output logic busy_o,
    output logic done_o
);

    localparam int CW = $clog2(MD_LAT + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MD_LAT - 1);

    md_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // State and down-counter registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (md_start_i) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller for the five-stage MIPS datapath.
// Resolves load-use, branch-in-Decode and HI/LO-consumer hazards with zero
// latency and counts stalled cycles in a saturating performance counter.
module stall_ctrl
    import mips_pkg::*;
#(
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs_d,
    input  logic [4:0]       rt_d,
    input  logic [4:0]       rt_e,
    input  logic             memtoreg_e,
    input  logic             regwrite_e,
    input  logic [4:0]       writereg_e,
    input  logic             memtoreg_m,
    input  logic [4:0]       writereg_m,
    input  logic             branch_d,
    input  logic             pcsrc_d,
    input  logic             md_use_d,
    input  logic             md_start_e,
    output logic             en_f,
    output logic             en_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             lwstall_s;
    logic             brstall_s;
    logic             mdstall_s;
    logic             stall_s;
    logic [CNT_W-1:0] stall_cnt_q;

    md_seq #(
        .MD_LAT (MD_LAT)
    ) u_md_seq (
        .clk        (clk),
        .rst        (rst),
        .md_start_i (md_start_e),
        .busy_o     (md_busy),
        .done_o     (md_done)
    );

    // Hazard detection and enable/flush generation; reset forces every control low.
    always_comb begin
        lwstall_s = memtoreg_e && reg_match(rt_e, rs_d, rt_d);
        brstall_s = branch_d &&
                    ((regwrite_e && reg_match(writereg_e, rs_d, rt_d)) ||
                     (memtoreg_m && reg_match(writereg_m, rs_d, rt_d)));
        mdstall_s = md_use_d && md_busy;
        stall_s   = lwstall_s || brstall_s || mdstall_s;
        if (rst) begin
            en_f    = 1'b0;
            en_d    = 1'b0;
            flush_d = 1'b0;
            flush_e = 1'b0;
        end else begin
            en_f    = !stall_s;
            en_d    = !stall_s;
            // A stall wins over a redirect; the branch is re-evaluated next cycle.
            flush_d = pcsrc_d && !stall_s;
            flush_e = stall_s;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_q <= stall_cnt_q;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
